// File: rtl/polar_crc_stream_if.sv
// Stream bundle for the polar/CRC encoder: frame input on one side, codeword output on the other.
// valid/ready: a transfer happens on a rising clk edge where valid && ready; the sender holds its payload stable until then.
interface polar_crc_stream_if #(
    parameter int K_DATA = 24,
    parameter int N      = 64
) ();
    logic              in_valid;
    logic              in_ready;
    logic [K_DATA-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      codeword;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, codeword
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, codeword
    );
endinterface

// File: rtl/polar_crc_stream_encoder.sv
// Multi-cycle polar encoder: CRC over the payload, info/frozen bit placement,
// then one polar butterfly stage per cycle, with a registered codeword output.
module polar_crc_stream_encoder #(
    parameter int                    LOG2N     = 6,
    parameter int                    K_DATA    = 24,
    parameter int                    CRC_W     = 16,
    parameter logic [CRC_W-1:0]      CRC_POLY  = 16'h1021,
    parameter logic [CRC_W-1:0]      CRC_INIT  = 16'hFFFF,
    parameter int                    CRC_BPC   = 8,
    parameter logic [(1<<LOG2N)-1:0] INFO_MASK = 64'hFFFE_FEE8_FEE8_E000
) (
    input  logic                clk,
    input  logic                rst_n,
    polar_crc_stream_if.slave   s,
    input  logic                abort,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic [1:0]          state_dbg
);
    localparam int N       = 1 << LOG2N;
    localparam int CRC_CYC = K_DATA / CRC_BPC;
    localparam int CW      = (CRC_CYC > 1) ? $clog2(CRC_CYC) : 1;
    localparam int SW      = $clog2(LOG2N);

    function automatic int rank_below(input int pos);
        int r = 0;
        for (int i = 0; i < pos; i++) r += int'(INFO_MASK[i]);
        return r;
    endfunction

    if (LOG2N < 3 || LOG2N > 10 || CRC_W < 8 || CRC_W > 32 || CRC_BPC < 1 ||
        (K_DATA % CRC_BPC) != 0 || rank_below(N) != K_DATA + CRC_W) begin : g_bad_params
        $error("polar_crc_stream_encoder: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, CRC, XFORM, OUT} state_t;

    state_t            state;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [K_DATA-1:0] data_reg;
    logic [K_DATA-1:0] data_sh;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_nxt;
    logic [CW-1:0]     crc_cnt;
    logic [SW-1:0]     stage;
    logic [N-1:0]      v;
    logic [N-1:0]      u_build;
    logic [N-1:0]      stage_out [LOG2N];
    logic              fb;

    assign s.in_ready  = in_ready_r;
    assign s.out_valid = out_valid_r;
    assign s.codeword  = v;
    assign state_dbg   = state;

    // CRC_BPC serial LFSR steps per cycle; data_sh always presents the next bit at its MSB.
    always_comb begin
        crc_nxt = crc_reg;
        fb      = 1'b0;
        for (int b = 0; b < CRC_BPC; b++) begin
            fb      = crc_nxt[CRC_W-1] ^ data_sh[K_DATA-1-b];
            crc_nxt = {crc_nxt[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

    // Info positions are ranked by ascending index: payload first (MSB first), then CRC (MSB first).
    for (genvar i = 0; i < N; i++) begin : g_place
        localparam int R = rank_below(i);
        if (INFO_MASK[i] && R < K_DATA) begin : g_data
            assign u_build[i] = data_reg[K_DATA-1-R];
        end else if (INFO_MASK[i] && R < K_DATA + CRC_W) begin : g_crc
            assign u_build[i] = crc_nxt[K_DATA+CRC_W-1-R];
        end else begin : g_frozen
            assign u_build[i] = 1'b0;
        end
    end

    for (genvar st = 0; st < LOG2N; st++) begin : g_stage
        for (genvar k = 0; k < N; k++) begin : g_bit
            if (((k >> st) & 1) == 0) begin : g_xor
                assign stage_out[st][k] = v[k] ^ v[k + (1 << st)];
            end else begin : g_pass
                assign stage_out[st][k] = v[k];
            end
        end
    end

    // Abort takes priority over every state action, including the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            data_reg    <= '0;
            data_sh     <= '0;
            crc_reg     <= '0;
            crc_cnt     <= '0;
            stage       <= '0;
            v           <= '0;
        end else if (abort) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s.in_valid) begin
                        data_reg   <= s.data_in;
                        data_sh    <= s.data_in;
                        crc_reg    <= CRC_INIT;
                        crc_cnt    <= '0;
                        in_ready_r <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CRC;
                    end
                end
                CRC: begin
                    crc_reg <= crc_nxt;
                    data_sh <= data_sh << CRC_BPC;
                    crc_cnt <= crc_cnt + 1'b1;
                    if (crc_cnt == CW'(CRC_CYC - 1)) begin
                        v     <= u_build;
                        stage <= '0;
                        state <= XFORM;
                    end
                end
                XFORM: begin
                    v     <= stage_out[stage];
                    stage <= stage + 1'b1;
                    if (stage == SW'(LOG2N - 1)) begin
                        out_valid_r <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (s.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy        <= 1'b0;
                        frame_cnt   <= frame_cnt + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
